// File: rtl/demux_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// demux_deserializer_pkg
// Shared constants for the 2:1 bit-demultiplexing deserializer.
//   WIDTH_DEF : default assembled word width
//   CH_A/CH_B : channel indices (select value that routes a bit to a channel)
//   NUM_CH    : number of demultiplexed channels
// ----------------------------------------------------------------------------
package demux_deserializer_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    localparam int CH_A   = 0;
    localparam int CH_B   = 1;
    localparam int NUM_CH = 2;

    // Per-channel steering request presented to a channel instance.
    typedef struct packed {
        logic bit_en;   // a qualified bit is routed to this channel this cycle
        logic din;      // the bit itself
        logic ack;      // consumer accepts the held word
    } ch_req_t;

endpackage : demux_deserializer_pkg

// File: rtl/demux_deserializer_if.sv
// ----------------------------------------------------------------------------
// demux_deserializer_if
// Bus bundle between the serial link / consumers and the deserializer.
//   din, select, valid : serial bit, channel select (0=A, 1=B), qualifier
//   ack_a, ack_b       : consumer accepts word_a / word_b
//   word_a, word_b     : last completed word per channel
//   valid_a, valid_b   : word register holds an unaccepted word
//   overrun_a/_b       : sticky, a completed word was dropped
// Modports: master = link/consumer side, slave = deserializer side.
// ----------------------------------------------------------------------------
interface demux_deserializer_if #(
    parameter int WIDTH = demux_deserializer_pkg::WIDTH_DEF
);
    logic             din;
    logic             select;
    logic             valid;
    logic             ack_a;
    logic             ack_b;
    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;
    logic             valid_a;
    logic             valid_b;
    logic             overrun_a;
    logic             overrun_b;

    modport master (
        output din, select, valid, ack_a, ack_b,
        input  word_a, word_b, valid_a, valid_b, overrun_a, overrun_b
    );

    modport slave (
        input  din, select, valid, ack_a, ack_b,
        output word_a, word_b, valid_a, valid_b, overrun_a, overrun_b
    );
endinterface : demux_deserializer_if

// File: rtl/demux_deserializer_channel.sv
// ----------------------------------------------------------------------------
// demux_channel
// One deserializer channel: shift register, bit counter, output word register,
// valid flag and sticky overrun flag.
//   clk, reset : clock, asynchronous active-high reset
//   req        : steered bit enable / data bit / consumer ack
//   word       : last completed word (held after ack)
//   word_vld   : word holds an unaccepted word
//   overrun    : sticky, a completed word found word_vld set without ack
// ----------------------------------------------------------------------------
module demux_channel
    import demux_deserializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  ch_req_t          req,
    output logic [WIDTH-1:0] word,
    output logic             word_vld,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_nxt;
    logic             last_bit;
    logic             can_load;

    // First bit received ends up in the MSB.
    assign sr_nxt   = {sr[WIDTH-2:0], req.din};
    assign last_bit = req.bit_en && (cnt == CNT_LAST);
    // Register is free if empty, or being emptied on this same edge.
    assign can_load = !word_vld || req.ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr       <= '0;
            cnt      <= '0;
            word     <= '0;
            word_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (req.bit_en) begin
                sr  <= sr_nxt;
                cnt <= last_bit ? '0 : cnt + CW'(1);
            end

            if (last_bit) begin
                if (can_load) begin
                    word     <= sr_nxt;
                    word_vld <= 1'b1;
                end else begin
                    // Word dropped; counter still wraps above so framing holds.
                    overrun  <= 1'b1;
                end
            end else if (req.ack && word_vld) begin
                word_vld <= 1'b0;
            end
        end
    end

endmodule : demux_channel

// File: rtl/demux_deserializer.sv
// ----------------------------------------------------------------------------
// demux_deserializer
// Receiving end of a 2:1 bit-multiplexed serial link. Each qualified bit is
// steered by select into one of two independent channel deserializers.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : demux_deserializer_if.slave (din/select/valid, acks, words, flags)
// ----------------------------------------------------------------------------
module demux_deserializer
    import demux_deserializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    demux_deserializer_if.slave    bus
);

    ch_req_t [NUM_CH-1:0]            req;
    logic    [NUM_CH-1:0]            ack;
    logic    [NUM_CH-1:0][WIDTH-1:0] word;
    logic    [NUM_CH-1:0]            word_vld;
    logic    [NUM_CH-1:0]            overrun;

    assign ack[CH_A] = bus.ack_a;
    assign ack[CH_B] = bus.ack_b;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign req[ch].bit_en = bus.valid && (bus.select == 1'(ch));
        assign req[ch].din    = bus.din;
        assign req[ch].ack    = ack[ch];

        demux_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .req      (req[ch]),
            .word     (word[ch]),
            .word_vld (word_vld[ch]),
            .overrun  (overrun[ch])
        );
    end

    assign bus.word_a    = word[CH_A];
    assign bus.word_b    = word[CH_B];
    assign bus.valid_a   = word_vld[CH_A];
    assign bus.valid_b   = word_vld[CH_B];
    assign bus.overrun_a = overrun[CH_A];
    assign bus.overrun_b = overrun[CH_B];

endmodule : demux_deserializer

// File: doc/demux_deserializer.md
DEMUX_DESERIALIZER -- requirements
Module: demux_deserializer

Interface
REQ-001 Parameter: WIDTH, default 4, bits per assembled word (legal range 2..16).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: din  input  1  serial data bit.
REQ-005 Port: select  input  1  channel select (0 = channel A, 1 = channel B).
REQ-006 Port: valid  input  1  din/select qualify strobe; both ignored when low.
REQ-007 Port: ack_a  input  1  consumer accepts word_a.
REQ-008 Port: ack_b  input  1  consumer accepts word_b.
REQ-009 Port: word_a  output  WIDTH  last completed channel-A word.
REQ-010 Port: word_b  output  WIDTH  last completed channel-B word.
REQ-011 Port: valid_a  output  1  word_a holds an unaccepted word.
REQ-012 Port: valid_b  output  1  word_b holds an unaccepted word.
REQ-013 Port: overrun_a  output  1  sticky: a channel-A word was dropped.
REQ-014 Port: overrun_b  output  1  sticky: a channel-B word was dropped.

Function
REQ-015 The block SHALL be the receiving end of a 2:1 bit-multiplexed link: each qualified bit is routed by select to exactly one channel.
REQ-016 Each channel SHALL own a WIDTH-bit shift register, a bit counter 0..WIDTH-1, an output register and a valid flag.
REQ-017 On a rising edge with valid=1, the selected channel SHALL shift left and insert din at LSB (first bit received ends in MSB) and increment its counter.
REQ-018 The unselected channel SHALL hold its shift register and counter unchanged (partial frames preserved across interleaving).
REQ-019 With valid=0, no shift register or counter SHALL change.
REQ-020 On the edge that samples a channel's WIDTH-th bit, the completed word (including that bit) SHALL load the output register, valid_x SHALL set and the counter SHALL wrap to 0; word visible the cycle after that edge (latency 1 clock from last bit).
REQ-021 valid_x SHALL clear on the edge where ack_x=1 and valid_x=1; word_x value SHALL remain unchanged after clearing.
REQ-022 ack_x with valid_x=0 SHALL be ignored.
REQ-023 Word completion and ack_x on the same edge with valid_x=1: new word loads, valid_x stays 1, no overrun.
REQ-024 Word completion with valid_x=1 and ack_x=0: new word dropped, word_x unchanged, counter still wraps to 0, overrun_x set.
REQ-025 overrun_x SHALL stay set until reset; it SHALL NOT affect further reception.
REQ-026 Channels SHALL be fully independent; activity or ack on one never alters the other.

Reset
REQ-027 reset=1 SHALL immediately, without clock, force: all shift registers, counters, word_a, word_b to 0; valid_a, valid_b, overrun_a, overrun_b to 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first qualified bit after release starts a new word at bit count 0.
REQ-029 No state SHALL change while reset is held, regardless of valid/ack.

Structure
REQ-030 A shared package SHALL hold the WIDTH default and channel index constants CH_A=0, CH_B=1.
REQ-031 One sub-module demux_channel (shift register, counter, output register, valid/overrun logic) SHALL be instantiated twice; the top contains only the select/valid steering.

Verification (WIDTH=4)
REQ-032 Reset, then 4 qualified bits 1,0,1,1 with select=0 -> word_a=4'b1011, valid_a=1 one clock after the 4th bit; valid_b=0.
REQ-033 Interleave A bits 1,1,0,0 with B bits 0,1,0,1 alternating select -> word_a=4'b1100, word_b=4'b0101, both valid.
REQ-034 Complete A word 1010 and hold ack_a=0, then send A 0110 -> word_a stays 1010, overrun_a=1; then pulse ack_a -> valid_a=0, overrun_a stays 1.
REQ-035 valid_a=1 with word 0011, 4th bit of next A word 1110 sampled with ack_a=1 same edge -> word_a=1110, valid_a=1, overrun_a=0.
REQ-036 Send 2 A bits, assert reset asynchronously between edges -> all outputs 0 immediately; release, send 1,0,0,1 -> word_a=4'b1001.
REQ-037 Toggle din/select with valid=0 for 8 cycles -> no output or counter change.
